// File: rtl/core_host_sequencer_pkg.sv
// rtl/core_host_sequencer_pkg.sv - shared state encoding and default sizing for the host sequencer
package core_host_sequencer_pkg;

    localparam int bw_default         = 4;
    localparam int psum_bw_default    = 16;
    localparam int row_default        = 8;
    localparam int col_default        = 8;
    localparam int addr_width_default = 8;
    localparam int x_len_default      = 144;
    localparam int w_len_default      = 72;
    localparam int len_onij_default   = 16;
    localparam int out_addr_w         = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_X,
        S_LOAD_W,
        S_RUN,
        S_READ,
        S_DRAIN
    } seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/core_host_sequencer_if.sv
// rtl/core_host_sequencer_if.sv - host streams and core memory bus seen by the sequencer
interface core_host_sequencer_if
    import core_host_sequencer_pkg::*;
#(
    parameter int bw         = bw_default,
    parameter int row        = row_default,
    parameter int psum_bw    = psum_bw_default,
    parameter int col        = col_default,
    parameter int addr_width = addr_width_default
) ();

    logic                    start;
    logic [bw*row-1:0]       in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [addr_width-1:0]   ADDR;
    logic                    ibank_selection;
    logic                    WEN;
    logic                    CEN;
    logic [bw*row-1:0]       data_in;
    logic                    mem_load_complete;
    logic                    convolution_complete;
    logic [psum_bw*col-1:0]  data_out;
    logic [psum_bw*col-1:0]  out_data;
    logic [out_addr_w-1:0]   out_addr;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, in_data, in_valid, convolution_complete, data_out, out_ready,
        output in_ready, ADDR, ibank_selection, WEN, CEN, data_in, mem_load_complete,
               out_data, out_addr, out_valid, busy, done
    );

    modport slave (
        output start, in_data, in_valid, convolution_complete, data_out, out_ready,
        input  in_ready, ADDR, ibank_selection, WEN, CEN, data_in, mem_load_complete,
               out_data, out_addr, out_valid, busy, done
    );

endinterface

// File: rtl/core_host_sequencer_fifo.sv
// rtl/core_host_sequencer_fifo.sv - two-entry synchronous FIFO buffering psum rows for the consumer
module sync_fifo2 #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    logic [width-1:0] mem_q [2];
    logic [width-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/core_host_sequencer.sv
// rtl/core_host_sequencer.sv - loads x/w banks into the core, starts it, and streams psum rows back out
module core_host_sequencer
    import core_host_sequencer_pkg::*;
#(
    parameter int bw         = bw_default,
    parameter int psum_bw    = psum_bw_default,
    parameter int row        = row_default,
    parameter int col        = col_default,
    parameter int addr_width = addr_width_default,
    parameter int x_len      = x_len_default,
    parameter int w_len      = w_len_default,
    parameter int len_onij   = len_onij_default
) (
    input  logic clk,
    input  logic reset,
    core_host_sequencer_if.master bus
);

    localparam int cnt_w  = $clog2(max3(x_len, w_len, len_onij) + 1);
    localparam int row_w  = psum_bw * col;
    localparam int fifo_w = row_w + out_addr_w;

    seq_state_e              state_q, state_d;
    logic [cnt_w-1:0]        cnt_q, cnt_d;
    logic                    in_ready_q, in_ready_d;
    logic                    cen_q, cen_d;
    logic                    wen_q, wen_d;
    logic                    ibank_q, ibank_d;
    logic [addr_width-1:0]   addr_q, addr_d;
    logic [bw*row-1:0]       data_in_q, data_in_d;
    logic                    mlc_q, mlc_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rd_issue_q, rd_issue_d;
    logic                    cap_q, cap_d;
    logic [out_addr_w-1:0]   cap_tag_q, cap_tag_d;

    logic                    hs;
    logic [2:0]              occ;
    logic                    can_read;
    logic                    fifo_full, fifo_empty, fifo_pop;
    logic [fifo_w-1:0]       fifo_rdata;

    // The core SRAM returns data the cycle after it samples CEN, so a read
    // stays in flight for two cycles (issued, then data on the bus) before it lands.
    sync_fifo2 #(.width(fifo_w)) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (cap_q),
        .push_data ({cap_tag_q, bus.data_out}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign hs       = bus.in_valid && in_ready_q;
    assign occ      = fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1);
    assign can_read = (occ + {2'b00, rd_issue_q} + {2'b00, cap_q}) <= 3'd1;
    assign fifo_pop = !fifo_empty && bus.out_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cen_d      = 1'b1;
        wen_d      = 1'b1;
        ibank_d    = ibank_q;
        addr_d     = addr_q;
        data_in_d  = data_in_q;
        done_d     = 1'b0;
        rd_issue_d = 1'b0;
        cap_d      = rd_issue_q;
        cap_tag_d  = rd_issue_q ? addr_q[out_addr_w-1:0] : cap_tag_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD_X;
                    cnt_d   = '0;
                end
            end
            S_LOAD_X, S_LOAD_W: begin
                if (hs) begin
                    cen_d     = 1'b0;
                    wen_d     = 1'b0;
                    ibank_d   = (state_q == S_LOAD_W);
                    addr_d    = addr_width'(cnt_q);
                    data_in_d = bus.in_data;
                    cnt_d     = cnt_q + cnt_w'(1);
                    if (state_q == S_LOAD_X && cnt_q == cnt_w'(x_len - 1)) begin
                        state_d = S_LOAD_W;
                        cnt_d   = '0;
                    end else if (state_q == S_LOAD_W && cnt_q == cnt_w'(w_len - 1)) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end
                end
            end
            S_RUN: begin
                if (bus.convolution_complete) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end
            end
            S_READ: begin
                if (can_read) begin
                    cen_d      = 1'b0;
                    addr_d     = addr_width'(cnt_q);
                    rd_issue_d = 1'b1;
                    cnt_d      = cnt_q + cnt_w'(1);
                    if (cnt_q == cnt_w'(len_onij - 1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_empty && !rd_issue_q && !cap_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LOAD_X) || (state_d == S_LOAD_W);
        mlc_d      = (state_d == S_RUN);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            cen_q      <= 1'b1;
            wen_q      <= 1'b1;
            ibank_q    <= 1'b0;
            addr_q     <= '0;
            data_in_q  <= '0;
            mlc_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_issue_q <= 1'b0;
            cap_q      <= 1'b0;
            cap_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            cen_q      <= cen_d;
            wen_q      <= wen_d;
            ibank_q    <= ibank_d;
            addr_q     <= addr_d;
            data_in_q  <= data_in_d;
            mlc_q      <= mlc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_issue_q <= rd_issue_d;
            cap_q      <= cap_d;
            cap_tag_q  <= cap_tag_d;
        end
    end

    assign bus.in_ready          = in_ready_q;
    assign bus.CEN               = cen_q;
    assign bus.WEN               = wen_q;
    assign bus.ibank_selection   = ibank_q;
    assign bus.ADDR              = addr_q;
    assign bus.data_in           = data_in_q;
    assign bus.mem_load_complete = mlc_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.out_valid         = !fifo_empty;
    assign bus.out_data          = fifo_rdata[row_w-1:0];
    assign bus.out_addr          = fifo_rdata[fifo_w-1:row_w];

endmodule

// File: doc/core_host_sequencer.md
CORE_HOST_SEQUENCER -- requirements
Module: core_host_sequencer

Interface
REQ-001 SHALL have parameters: bw=4 (activation/weight bits); psum_bw=16 (psum bits); row=8 (input channels); col=8 (output channels); addr_width=8 (core ADDR bits); x_len=144 (x_bank words to load); w_len=72 (w_bank words to load); len_onij=16 (psum rows to read back).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a job when IDLE
- in_data  in  bw*row  x words then w words, in order
- in_valid  in  1  in_data valid
- in_ready  out  1  sequencer accepts in_data
- ADDR  out  addr_width  core memory address
- ibank_selection  out  1  0 = x_bank, 1 = w_bank
- WEN  out  1  0 = write, 1 = read
- CEN  out  1  0 = memory enabled
- data_in  out  bw*row  core write data
- mem_load_complete  out  1  starts core controller
- convolution_complete  in  1  core finished, psum bank valid
- data_out  in  psum_bw*col  core psum read data
- out_data  out  psum_bw*col  psum row to consumer
- out_addr  out  4  psum row index of out_data
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when job ends

Function
REQ-003 SHALL implement FSM IDLE -> LOAD_X -> LOAD_W -> RUN -> READ -> DRAIN -> IDLE.
REQ-004 IDLE: in_ready=0; start=1 -> LOAD_X, counter cleared; start outside IDLE SHALL be ignored.
REQ-005 LOAD_X/LOAD_W: in_ready=1; each in_valid&&in_ready handshake SHALL drive, on the next cycle, CEN=0, WEN=0, ibank_selection=0/1, ADDR=counter, data_in=in_data, then increment counter; non-handshake cycles SHALL drive CEN=1, WEN=1.
REQ-006 After handshake x_len-1, SHALL go LOAD_X -> LOAD_W with counter cleared; after handshake w_len-1, LOAD_W -> RUN.
REQ-007 RUN: mem_load_complete SHALL be 1 from the first RUN cycle until the cycle after convolution_complete is sampled 1, then 0; CEN=1, WEN=1.
REQ-008 A convolution_complete=1 sample SHALL move RUN -> READ with counter cleared.
REQ-009 READ: each issued read SHALL drive CEN=0, WEN=1, ADDR=counter (zero-extended); data_out SHALL be captured exactly one cycle later into the output FIFO, tagged with the row index.
REQ-010 A read SHALL be issued only when FIFO free entries minus in-flight reads >= 1; psum rows SHALL never be dropped or duplicated under any out_ready pattern.
REQ-011 After read len_onij-1 is issued, SHALL go READ -> DRAIN; DRAIN -> IDLE when the FIFO is empty and no read is in flight, pulsing done=1 for one cycle.
REQ-012 out_valid SHALL equal FIFO not-empty; a pop SHALL occur on out_valid&&out_ready; out_data/out_addr SHALL remain stable while out_valid=1 and out_ready=0.
REQ-013 Rows SHALL be emitted in ascending out_addr 0..len_onij-1.
REQ-014 All core-facing outputs SHALL be registered; no combinational path from in_valid or out_ready to any output except none.
REQ-015 Counters SHALL be sized to hold max(x_len, w_len, len_onij) and SHALL never wrap within a job.

Reset
REQ-016 reset=0 SHALL asynchronously force: state IDLE, counters 0, FIFO empty, in_ready=0, CEN=1, WEN=1, ibank_selection=0, ADDR=0, data_in=0, mem_load_complete=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0.
REQ-017 Reset mid-job SHALL abandon the job; no further writes SHALL occur, and after release the block SHALL wait in IDLE for start.

Structure
REQ-018 FSM state enum and default parameter values SHALL live in the shared core package.
REQ-019 The output buffer SHALL be a separate 2-entry synchronous FIFO sub-module, sync_fifo2, with push/pop/full/empty.

Verification
REQ-020 Full load with in_valid constant 1: 144 x writes to ADDR 0..143 with ibank_selection=0, then 72 w writes to ADDR 0..71 with ibank_selection=1; mem_load_complete rises on the following cycle.
REQ-021 in_valid toggled 1,0,1,0 during LOAD_X -> writes occur only after handshakes; CEN=1 in gaps; addresses contiguous.
REQ-022 convolution_complete pulsed with psum row k = k*0x11: out_ready constant 1 -> 16 rows, out_addr 0..15, correct data, done pulses once.
REQ-023 out_ready low for 10 cycles in READ -> at most 2 rows buffered, reads stall, no loss; data stable while stalled; all 16 rows are delivered after release.
REQ-024 reset asserted at LOAD_W word 30 -> all outputs take reset values immediately; a new start reloads from x ADDR 0.
REQ-025 start pulsed during RUN -> ignored; the job completes normally.
